// File: rtl/pim_conv_line_seq.sv
// Time-multiplexed PIM convolution line: reads NUM_TILES partial sums from one tile port into a saturating accumulator.
// Optional build macro PIM_CONV_RELU_EN clamps a negative result to zero on entry to DONE.
module pim_conv_line_seq #(
   parameter int SIZE       = 512,
   parameter int TILE_SIZE  = 128,
   parameter int PSUM_WIDTH = 9,
   parameter int OUT_WIDTH  = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         start,
   output logic                         busy,
   output logic                         tile_rd,
   output logic [ADDR_WIDTH-1:0]        tile_addr,
   input  logic signed [PSUM_WIDTH-1:0] tile_psum,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_WIDTH-1:0]  convValue,
   output logic                         sat
);

   localparam int NUM_TILES = (SIZE + TILE_SIZE - 1) / TILE_SIZE;
   // One extra bit so the issue counter can reach NUM_TILES even when it equals 2**ADDR_WIDTH.
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] C_NUM = CNT_W'(NUM_TILES);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
   localparam logic signed [OUT_WIDTH:0] C_MAX = {2'b00, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH:0] C_MIN = {2'b11, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [CNT_W-1:0]            r_issue_cnt;
   logic [CNT_W-1:0]            r_acc_cnt;
   logic                        r_rd_q;
   logic signed [OUT_WIDTH-1:0] r_acc;
   logic                        r_sat;

   logic                        w_start_acc;
   logic                        w_hs;
   logic                        w_run_done;
   logic signed [OUT_WIDTH:0]   w_sum;
   logic signed [OUT_WIDTH-1:0] w_sum_clip;
   logic                        w_clip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_start_acc = 1'b0;
      w_hs        = 1'b0;
      w_run_done  = 1'b0;
      busy        = 1'b0;
      tile_rd     = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_next      = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            tile_rd = en && (r_issue_cnt < C_NUM);
            if (r_acc_cnt == C_NUM) begin
               w_run_done = 1'b1;
               w_next     = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_hs   = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Sum is one bit wider than the accumulator so overflow is visible before clamping.
   always_comb begin
      w_sum      = (OUT_WIDTH+1)'(r_acc) + (OUT_WIDTH+1)'(tile_psum);
      w_clip     = 1'b0;
      w_sum_clip = w_sum[OUT_WIDTH-1:0];
      if (w_sum > C_MAX) begin
         w_clip     = 1'b1;
         w_sum_clip = C_MAX[OUT_WIDTH-1:0];
      end else if (w_sum < C_MIN) begin
         w_clip     = 1'b1;
         w_sum_clip = C_MIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_acc_cnt   <= '0;
         r_rd_q      <= 1'b0;
         r_acc       <= '0;
         r_sat       <= 1'b0;
      end else begin
         r_rd_q <= tile_rd;
         if (w_start_acc) begin
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
         end else if (r_state == S_RUN) begin
            if (tile_rd) begin
               r_issue_cnt <= r_issue_cnt + C_ONE;
            end
            // Returning data is taken independent of en so an in-flight read is never dropped.
            if (r_rd_q) begin
               r_acc     <= w_sum_clip;
               r_acc_cnt <= r_acc_cnt + C_ONE;
               if (w_clip) begin
                  r_sat <= 1'b1;
               end
            end
`ifdef PIM_CONV_RELU_EN
            if (w_run_done && r_acc[OUT_WIDTH-1]) begin
               r_acc <= '0;
            end
`endif
         end else if (w_hs) begin
            r_issue_cnt <= '0;
         end
      end
   end

   assign tile_addr = r_issue_cnt[ADDR_WIDTH-1:0];
   assign convValue = r_acc;
   assign sat       = r_sat;

endmodule

// File: tb/tb_pim_conv_line_seq.sv
// Directed bench for pim_conv_line_seq: default, narrow-accumulator and single-tile instances share control inputs.
module tb_pim_conv_line_seq;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic start;
   logic out_ready;

   always #5 clk = ~clk;

   logic              m_busy, m_rd, m_ov, m_sat;
   logic [4:0]        m_addr;
   logic signed [8:0] m_psum;
   logic signed [15:0] m_cv;

   logic              s_busy, s_rd, s_ov, s_sat;
   logic [4:0]        s_addr;
   logic signed [8:0] s_psum;
   logic signed [9:0] s_cv;

   logic              o_busy, o_rd, o_ov, o_sat;
   logic [4:0]        o_addr;
   logic signed [8:0] o_psum;
   logic signed [15:0] o_cv_sig;

   pim_conv_line_seq u_main (
      .clk(clk), .rst(rst), .en(en), .start(start), .busy(m_busy),
      .tile_rd(m_rd), .tile_addr(m_addr), .tile_psum(m_psum),
      .out_valid(m_ov), .out_ready(out_ready), .convValue(m_cv), .sat(m_sat)
   );

   pim_conv_line_seq #(.OUT_WIDTH(10)) u_narrow (
      .clk(clk), .rst(rst), .en(en), .start(start), .busy(s_busy),
      .tile_rd(s_rd), .tile_addr(s_addr), .tile_psum(s_psum),
      .out_valid(s_ov), .out_ready(out_ready), .convValue(s_cv), .sat(s_sat)
   );

   pim_conv_line_seq #(.SIZE(100)) u_one (
      .clk(clk), .rst(rst), .en(en), .start(start), .busy(o_busy),
      .tile_rd(o_rd), .tile_addr(o_addr), .tile_psum(o_psum),
      .out_valid(o_ov), .out_ready(out_ready), .convValue(o_cv_sig), .sat(o_sat)
   );

   int tab_m[4];
   int tab_s[4];
   int tab_o;
   int total = 0;
   int bad = 0;
   int addr_log[$];
   int o_lat;
   longint o_cv;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint relu(input longint v);
`ifdef PIM_CONV_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Tile memory model: a read seen in one cycle returns data in the next; idle cycles carry junk.
   logic       m_rd_s, s_rd_s, o_rd_s;
   logic [1:0] m_a_s, s_a_s;
   always @(negedge clk) begin
      m_rd_s = m_rd;
      s_rd_s = s_rd;
      o_rd_s = o_rd;
      m_a_s  = m_addr[1:0];
      s_a_s  = s_addr[1:0];
   end
   always @(posedge clk) begin
      #1;
      m_psum = m_rd_s ? 9'(tab_m[m_a_s]) : 9'sd77;
      s_psum = s_rd_s ? 9'(tab_s[s_a_s]) : 9'sd77;
      o_psum = o_rd_s ? 9'(tab_o) : 9'sd77;
   end

   task automatic run(input int gs, input int gl, output int lat, output int nrd, output int gaprd);
      lat   = -1;
      nrd   = 0;
      gaprd = 0;
      o_lat = -1;
      o_cv  = 0;
      addr_log.delete();
      start = 1'b1;
      en    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         en = !(cyc >= gs && cyc < gs + gl);
         #1;
         if (m_rd) begin
            nrd++;
            addr_log.push_back(int'(m_addr));
            if (!en) gaprd++;
         end
         if (o_ov && o_lat < 0) begin
            o_lat = cyc - 1;
            o_cv  = o_cv_sig;
         end
         if (m_ov) begin
            lat = cyc - 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      en = 1'b1;
   endtask

   task automatic set_m(input int a, input int b, input int c, input int d);
      tab_m[0] = a; tab_m[1] = b; tab_m[2] = c; tab_m[3] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, nrd, gaprd;
      rst = 1'b0; en = 1'b0; start = 1'b0; out_ready = 1'b1;
      set_m(10, 20, -5, 100);
      for (int i = 0; i < 4; i++) tab_s[i] = i + 1;
      tab_o = 42;
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", m_busy, 0);
      chk("rst_rd", m_rd, 0);
      chk("rst_ov", m_ov, 0);
      chk("rst_sat", m_sat, 0);
      chk("rst_addr", m_addr, 0);
      chk("rst_cv", m_cv, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      // Basic sum, address order and latency; single-tile instance runs alongside.
      run(100, 0, lat, nrd, gaprd);
      chk("t1_lat", lat, 6);
      chk("t1_nrd", nrd, 4);
      for (int i = 0; i < addr_log.size(); i++) chk("t1_addr", addr_log[i], i);
      chk("t1_cv", m_cv, 125);
      chk("t1_sat", m_sat, 0);
      chk("t1_narrow_cv", s_cv, 10);
      chk("t1_one_lat", o_lat, 3);
      chk("t1_one_cv", o_cv, 42);
      step();
      chk("t1_busy_after", m_busy, 0);
      chk("t1_ov_after", m_ov, 0);

      // Saturation on a 10-bit accumulator, both directions.
      set_m(255, 255, 255, 255);
      for (int i = 0; i < 4; i++) tab_s[i] = 255;
      run(100, 0, lat, nrd, gaprd);
      chk("t2_pos_cv", s_cv, 511);
      chk("t2_pos_sat", s_sat, 1);
      chk("t2_wide_cv", m_cv, 1020);
      chk("t2_wide_sat", m_sat, 0);
      step();
      set_m(-256, -256, -256, -256);
      for (int i = 0; i < 4; i++) tab_s[i] = -256;
      run(100, 0, lat, nrd, gaprd);
      chk("t2_neg_cv", s_cv, relu(-512));
      chk("t2_neg_sat", s_sat, 1);
      chk("t2_wide_neg_cv", m_cv, relu(-1024));
      step();

      // en stall after the second read.
      set_m(10, 20, -5, 100);
      run(3, 3, lat, nrd, gaprd);
      chk("t3_lat", lat, 9);
      chk("t3_nrd", nrd, 4);
      chk("t3_gap_rd", gaprd, 0);
      for (int i = 0; i < addr_log.size(); i++) chk("t3_addr", addr_log[i], i);
      chk("t3_cv", m_cv, 125);
      step();

      // Output backpressure with ignored start pulses.
      out_ready = 1'b0;
      run(100, 0, lat, nrd, gaprd);
      chk("t4_lat", lat, 6);
      for (int k = 0; k < 5; k++) begin
         start = (k == 1 || k == 3);
         @(posedge clk);
         #1 start = 1'b0;
         #1;
         chk("t4_hold_cv", m_cv, 125);
         chk("t4_hold_busy", m_busy, 1);
         chk("t4_hold_ov", m_ov, 1);
      end
      out_ready = 1'b1;
      step();
      chk("t4_hs_busy", m_busy, 0);
      chk("t4_hs_ov", m_ov, 0);
      step();
      chk("t4_no_queue", m_busy, 0);

      // Fresh start after handshake, negative result (ReLU build clamps to 0).
      set_m(-50, 10, 5, 5);
      run(100, 0, lat, nrd, gaprd);
      chk("t6_lat", lat, 6);
      chk("t6_cv", m_cv, relu(-30));
      chk("t6_sat", m_sat, 0);
      step();

      // Reset mid-run after two reads.
      set_m(10, 20, -5, 100);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      en = 1'b1;
      #1 chk("t5_rd0", m_rd, 1);
      step();
      chk("t5_rd1_addr", m_addr, 1);
      @(posedge clk);
      #1 chk("t5_pre_cv", m_cv, 10);
      rst = 1'b1;
      #1;
      chk("t5_rd", m_rd, 0);
      chk("t5_busy", m_busy, 0);
      chk("t5_ov", m_ov, 0);
      chk("t5_cv", m_cv, 0);
      #1 rst = 1'b0;
      step();
      chk("t5_ignored_cv", m_cv, 0);
      chk("t5_idle_busy", m_busy, 0);
      run(100, 0, lat, nrd, gaprd);
      chk("t5_fresh_lat", lat, 6);
      chk("t5_fresh_cv", m_cv, 125);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
